// File: rtl/morse_pkg.sv
// Shared definitions for the Morse decipher block.
// Holds output code constants, timing thresholds, the timing FSM state type,
// the symbol buffer record and small helper functions used by main.
package morse_pkg;

   // Output character codes
   localparam logic [5:0] CODE_SPACE   = 6'd36;
   localparam logic [5:0] CODE_INVALID = 6'd63;
   localparam logic [5:0] CODE_RESET   = 6'd63;

   // Thresholds, in unit ticks unless noted
   localparam int unsigned DASH_TICKS     = 3;
   localparam int unsigned CHAR_GAP_TICKS = 3;
   localparam int unsigned WORD_GAP_TICKS = 7;
   localparam int unsigned FILTER_LEN     = 3;   // clk samples
   localparam int unsigned BASE_DIV       = 12;  // clk cycles per tick at spec=0
   localparam int unsigned MAX_SYMBOLS    = 5;

   // StIdle: line low, buffer empty. StMark: line high. StGap: line low, buffer holds symbols.
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StMark = 2'd1,
      StGap  = 2'd2
   } run_state_e;

   typedef enum logic {
      LastSpace = 1'b0,
      LastChar  = 1'b1
   } last_emit_e;

   // First symbol lives in pat[0]; dot = 0, dash = 1.
   typedef struct packed {
      logic       ovf;
      logic [2:0] len;
      logic [4:0] pat;
   } sym_buf_t;

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   // Append one symbol; beyond MAX_SYMBOLS only the overflow flag changes.
   function automatic sym_buf_t push_symbol(input sym_buf_t b, input logic dash);
      sym_buf_t r;
      r = b;
      if (b.len < 3'(MAX_SYMBOLS)) begin
         r.pat = b.pat | (5'(dash) << b.len);
         r.len = b.len + 3'd1;
      end else begin
         r.ovf = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/morse_symbol_lut.sv
// Combinational ITU Morse pattern decoder.
// Ports:
//   len_i     - number of symbols (1..5)
//   pattern_i - symbols, first in bit 0, dot = 0, dash = 1; unused bits zero
//   code_o    - 0..25 = A..Z, 26..35 = digits 0..9, 63 = unknown pattern
module morse_symbol_lut
   import morse_pkg::*;
(
   input  logic [2:0] len_i,
   input  logic [4:0] pattern_i,
   output logic [5:0] code_o
);

   always_comb begin
      code_o = CODE_INVALID;
      case ({len_i, pattern_i})
         {3'd2, 5'd2}:  code_o = 6'd0;   // A .-
         {3'd4, 5'd1}:  code_o = 6'd1;   // B -...
         {3'd4, 5'd5}:  code_o = 6'd2;   // C -.-.
         {3'd3, 5'd1}:  code_o = 6'd3;   // D -..
         {3'd1, 5'd0}:  code_o = 6'd4;   // E .
         {3'd4, 5'd4}:  code_o = 6'd5;   // F ..-.
         {3'd3, 5'd3}:  code_o = 6'd6;   // G --.
         {3'd4, 5'd0}:  code_o = 6'd7;   // H ....
         {3'd2, 5'd0}:  code_o = 6'd8;   // I ..
         {3'd4, 5'd14}: code_o = 6'd9;   // J .---
         {3'd3, 5'd5}:  code_o = 6'd10;  // K -.-
         {3'd4, 5'd2}:  code_o = 6'd11;  // L .-..
         {3'd2, 5'd3}:  code_o = 6'd12;  // M --
         {3'd2, 5'd1}:  code_o = 6'd13;  // N -.
         {3'd3, 5'd7}:  code_o = 6'd14;  // O ---
         {3'd4, 5'd6}:  code_o = 6'd15;  // P .--.
         {3'd4, 5'd11}: code_o = 6'd16;  // Q --.-
         {3'd3, 5'd2}:  code_o = 6'd17;  // R .-.
         {3'd3, 5'd0}:  code_o = 6'd18;  // S ...
         {3'd1, 5'd1}:  code_o = 6'd19;  // T -
         {3'd3, 5'd4}:  code_o = 6'd20;  // U ..-
         {3'd4, 5'd8}:  code_o = 6'd21;  // V ...-
         {3'd3, 5'd6}:  code_o = 6'd22;  // W .--
         {3'd4, 5'd9}:  code_o = 6'd23;  // X -..-
         {3'd4, 5'd13}: code_o = 6'd24;  // Y -.--
         {3'd4, 5'd3}:  code_o = 6'd25;  // Z --..
         {3'd5, 5'd31}: code_o = 6'd26;  // 0 -----
         {3'd5, 5'd30}: code_o = 6'd27;  // 1 .----
         {3'd5, 5'd28}: code_o = 6'd28;  // 2 ..---
         {3'd5, 5'd24}: code_o = 6'd29;  // 3 ...--
         {3'd5, 5'd16}: code_o = 6'd30;  // 4 ....-
         {3'd5, 5'd0}:  code_o = 6'd31;  // 5 .....
         {3'd5, 5'd1}:  code_o = 6'd32;  // 6 -....
         {3'd5, 5'd3}:  code_o = 6'd33;  // 7 --...
         {3'd5, 5'd7}:  code_o = 6'd34;  // 8 ---..
         {3'd5, 5'd15}: code_o = 6'd35;  // 9 ----.
         default:       code_o = CODE_INVALID;
      endcase
   end

endmodule

// File: rtl/main.sv
// Morse-code decipher top block.
// Synchronizes and deglitches a raw keying line, times mark/space runs in unit
// ticks, classifies marks as dot/dash, and emits one 6-bit code per character
// (or word space) with a single-cycle strobe.
// Ports:
//   clk        - clock
//   rst        - asynchronous active-low reset
//   noisy_in   - raw keying line (async), high = key down
//   spec       - tick rate select, tick period = 12 * 2^spec clk cycles
//   char_out   - last decoded code, held between strobes (63 after reset)
//   char_ready - one-cycle strobe, char_out valid in the same cycle
module main
   import morse_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       noisy_in,
   input  logic [2:0] spec,
   output logic [5:0] char_out,
   output logic       char_ready
);

   // ---------------- synchronizer ----------------
   logic sync1_q, sync2_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= noisy_in;
         sync2_q <= sync1_q;
      end
   end

   // ---------------- deglitch filter ----------------
   logic       filt_q, filt_d, filt_change;
   logic [1:0] flt_cnt_q, flt_cnt_d;

   // flt_cnt counts consecutive samples disagreeing with the filtered level.
   always_comb begin
      filt_d      = filt_q;
      flt_cnt_d   = 2'd0;
      filt_change = 1'b0;
      if (sync2_q != filt_q) begin
         if (flt_cnt_q == 2'(FILTER_LEN - 1)) begin
            filt_d      = sync2_q;
            filt_change = 1'b1;
         end else begin
            flt_cnt_d = flt_cnt_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         filt_q    <= 1'b0;
         flt_cnt_q <= 2'd0;
      end else begin
         filt_q    <= filt_d;
         flt_cnt_q <= flt_cnt_d;
      end
   end

   // ---------------- tick generator ----------------
   logic [2:0]  spec_q;
   logic [10:0] tick_cnt_q, tick_cnt_d, period_m1;
   logic        tick;

   always_comb begin
      period_m1 = (11'(BASE_DIV) << spec) - 11'd1;
      tick      = (spec == spec_q) && (tick_cnt_q == period_m1);
      if ((spec != spec_q) || tick) begin
         tick_cnt_d = 11'd0;
      end else begin
         tick_cnt_d = tick_cnt_q + 11'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         spec_q     <= 3'd0;
         tick_cnt_q <= 11'd0;
      end else begin
         spec_q     <= spec;
         tick_cnt_q <= tick_cnt_d;
      end
   end

   // ---------------- run timing ----------------
   logic [3:0] run_q, run_d;
   logic [4:0] mark_ticks;
   logic       is_dash, char_gap_hit, word_gap_hit;

   always_comb begin
      if (filt_change) begin
         run_d = 4'd0;
      end else if (tick) begin
         run_d = sat_inc(run_q);
      end else begin
         run_d = run_q;
      end
      // A tick landing on the edge cycle belongs to the run that is ending.
      mark_ticks   = {1'b0, run_q} + {4'd0, tick};
      is_dash      = (mark_ticks >= 5'(DASH_TICKS));
      char_gap_hit = tick && !filt_q && (run_q == 4'(CHAR_GAP_TICKS - 1));
      word_gap_hit = tick && !filt_q && (run_q == 4'(WORD_GAP_TICKS - 1));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_q <= 4'd0;
      end else begin
         run_q <= run_d;
      end
   end

   // ---------------- symbol decode ----------------
   sym_buf_t   buf_q, buf_d;
   logic [5:0] lut_code;

   morse_symbol_lut u_lut (
      .len_i     (buf_q.len),
      .pattern_i (buf_q.pat),
      .code_o    (lut_code)
   );

   // ---------------- timing FSM ----------------
   run_state_e state_q, state_d;
   last_emit_e last_q, last_d;
   logic       emit;
   logic [5:0] emit_code;
   logic [5:0] char_out_q;
   logic       char_ready_q;

   // While in StIdle/StGap the filtered level is low, so filt_change is a rise;
   // in StMark it is a fall.
   always_comb begin
      state_d   = state_q;
      buf_d     = buf_q;
      last_d    = last_q;
      emit      = 1'b0;
      emit_code = char_out_q;
      unique case (state_q)
         StIdle: begin
            if (word_gap_hit && (last_q == LastChar)) begin
               emit      = 1'b1;
               emit_code = CODE_SPACE;
               last_d    = LastSpace;
            end
            if (filt_change) begin
               state_d = StMark;
            end
         end
         StMark: begin
            if (filt_change) begin
               buf_d   = push_symbol(buf_q, is_dash);
               state_d = StGap;
            end
         end
         StGap: begin
            if (char_gap_hit) begin
               emit      = 1'b1;
               emit_code = buf_q.ovf ? CODE_INVALID : lut_code;
               last_d    = LastChar;
               buf_d     = '0;
               state_d   = filt_change ? StMark : StIdle;
            end else if (filt_change) begin
               state_d = StMark;
            end
         end
         default: begin
            state_d = StIdle;
            buf_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         buf_q        <= '0;
         last_q       <= LastSpace;
         char_out_q   <= CODE_RESET;
         char_ready_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         buf_q        <= buf_d;
         last_q       <= last_d;
         char_ready_q <= emit;
         if (emit) begin
            char_out_q <= emit_code;
         end
      end
   end

   assign char_out   = char_out_q;
   assign char_ready = char_ready_q;

endmodule

// File: tb/tb_main.sv
// Self-checking bench for the Morse decipher: directed steps followed by
// randomized characters decoded by a string-table reference model.
module tb_main;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       noisy_in = 1'b0;
   logic [2:0] spec = 3'd0;
   logic [5:0] char_out;
   logic       char_ready;

   int checks = 0;
   int errors = 0;
   int got_q[$];
   int p = 12;

   string tab[36] = '{
      ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
      "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
      "..-", "...-", ".--", "-..-", "-.--", "--..",
      "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."
   };
   string bad[7] = '{"..--", ".-.-", "---.", "----", "..-..", "......", "-.-.-.-"};

   main dut (
      .clk        (clk),
      .rst        (rst),
      .noisy_in   (noisy_in),
      .spec       (spec),
      .char_out   (char_out),
      .char_ready (char_ready)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (char_ready) got_q.push_back(int'(char_out));
   end

   function automatic int decode(input string s);
      if (s.len() > 5) return 63;
      for (int i = 0; i < 36; i++) begin
         if (tab[i] == s) return i;
      end
      return 63;
   endfunction

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic level(input logic v, input int n);
      noisy_in = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic expect_strobes(input string tag, input int n, input int c0, input int c1);
      check({tag, " strobes"}, got_q.size(), n);
      if (got_q.size() == n && n > 0) begin
         check({tag, " code0"}, got_q[0], c0);
         if (n > 1) check({tag, " code1"}, got_q[1], c1);
         check({tag, " hold"}, int'(char_out), (n > 1) ? c1 : c0);
      end
      got_q.delete();
   endtask

   // Marks/gaps are kept clear of the tick boundaries so the tick phase never matters.
   task automatic send_char(input string s);
      byte ch;
      for (int i = 0; i < s.len(); i++) begin
         ch = s[i];
         if (ch == "-") level(1'b1, $urandom_range(4 * p, 3 * p));
         else           level(1'b1, $urandom_range(2 * p, 4));
         if (i < s.len() - 1) level(1'b0, $urandom_range(2 * p, 4));
      end
   endtask

   task automatic random_char(input string tag, input string s);
      int exp;
      exp = decode(s);
      send_char(s);
      if ($urandom_range(3, 0) == 0) begin
         level(1'b0, $urandom_range(8 * p, 7 * p + 8));
         expect_strobes(tag, 2, exp, 36);
      end else begin
         level(1'b0, $urandom_range(6 * p - 1, 3 * p + 8));
         expect_strobes(tag, 1, exp, 0);
      end
   endtask

   initial begin
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset char_out", int'(char_out), 63);
      check("reset char_ready", int'(char_ready), 0);
      rst = 1'b1;
      spec = 3'd0;
      p = 12;
      level(1'b0, 20);

      level(1'b1, 24); level(1'b0, 60);
      expect_strobes("E", 1, 4, 0);
      level(1'b1, 48); level(1'b0, 60);
      expect_strobes("T", 1, 19, 0);
      level(1'b1, 24); level(1'b0, 12); level(1'b1, 48); level(1'b0, 60);
      expect_strobes("A", 1, 0, 0);
      level(1'b0, 100);
      expect_strobes("A word", 1, 36, 0);

      do_reset();
      for (int i = 0; i < 25; i++) begin
         level(1'b1, 2); level(1'b0, 18);
      end
      expect_strobes("glitch", 0, 0, 0);
      check("glitch char_out", int'(char_out), 63);

      for (int i = 0; i < 6; i++) begin
         level(1'b1, 24);
         if (i < 5) level(1'b0, 12);
      end
      level(1'b0, 60);
      expect_strobes("six dots", 1, 63, 0);
      level(1'b0, 100);
      expect_strobes("six dots word", 1, 36, 0);
      level(1'b0, 200);
      expect_strobes("no repeat", 0, 0, 0);

      spec = 3'd1;
      p = 24;
      level(1'b0, 30);
      level(1'b1, 48); level(1'b0, 100);
      expect_strobes("E spec1", 1, 4, 0);

      level(1'b1, 48); level(1'b0, 12);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("midreset char_out", int'(char_out), 63);
      check("midreset char_ready", int'(char_ready), 0);
      rst = 1'b1;
      level(1'b0, 300);
      expect_strobes("reset discard", 0, 0, 0);
      check("discard char_out", int'(char_out), 63);

      // Every code plus invalid patterns at the fastest rate
      do_reset();
      spec = 3'd0;
      p = 12;
      level(1'b0, 30);
      for (int c = 0; c < 36; c++) random_char($sformatf("code%0d", c), tab[c]);
      for (int b = 0; b < 7; b++) random_char($sformatf("bad%0d", b), bad[b]);

      // Random characters at a slower rate
      do_reset();
      spec = 3'($urandom_range(2, 1));
      p = 12 << spec;
      level(1'b0, 30);
      for (int k = 0; k < 6; k++) begin
         int c;
         c = $urandom_range(35, 0);
         random_char($sformatf("rnd%0d code%0d spec%0d", k, c, spec), tab[c]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
